assoc_cache_ctrl: RTL

//  Parametrised N-way set-associative write-back, write-allocate cache with built-in tag/data arrays.

---
 rtl/assoc_cache_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_cache_ctrl
//  Description : N-way set-associative, write-back / write-allocate cache
//                controller with built-in tag, valid, dirty and data arrays,
//                per-set round-robin replacement and a word-wide req/ack
//                backing-memory port.
//                Optional feature macro: CACHE_STATS_EN (adds saturating
//                hit_cnt / miss_cnt outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_cache_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAYS   = 2,
    parameter int SETS   = 256,
    parameter int LINE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF   = $clog2(LINE_W);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX - 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                wr_q, wr_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                vic_valid_q, vic_valid_d;
    logic [OFF-1:0]      k_q, k_d;

    // Storage arrays; only valid/dirty/round-robin state is reset
    logic [TAG_W-1:0]    tag_arr   [WAYS][SETS];
    logic                valid_arr [WAYS][SETS];
    logic                dirty_arr [WAYS][SETS];
    logic [DATA_W-1:0]   data_arr  [WAYS][SETS][LINE_W];
    logic [WAY_W-1:0]    rr_q      [SETS];

    // Live request decode and captured-request decode
    logic [TAG_W-1:0]    req_tag, cap_tag;
    logic [IDX-1:0]      req_idx, cap_idx;
    logic [OFF-1:0]      req_word, cap_word;
    logic                bad_req, k_last;

    assign req_tag  = Addr[ADDR_W-1:OFF+IDX+1];
    assign req_idx  = Addr[OFF+IDX:OFF+1];
    assign req_word = Addr[OFF:1];
    assign cap_tag  = addr_q[ADDR_W-1:OFF+IDX+1];
    assign cap_idx  = addr_q[OFF+IDX:OFF+1];
    assign cap_word = addr_q[OFF:1];
    assign bad_req  = (Rd && Wr) || Addr[0];
    assign k_last   = (k_q == OFF'(LINE_W - 1));
    assign Stall    = (state_q != S_IDLE);

    // Array write-port controls shared by hit writes, fills and miss responses
    logic                arr_we, line_fill, dirty_set, rr_adv;
    logic [WAY_W-1:0]    arr_way;
    logic [IDX-1:0]      arr_idx;
    logic [OFF-1:0]      arr_word;
    logic [DATA_W-1:0]   arr_wdata;

    // Lookup: hit way and lowest-index invalid way in the addressed set
    logic                hit, any_inv;
    logic [WAY_W-1:0]    hit_way, inv_way;

    // Compare all ways in parallel; descending scan leaves the lowest index
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_arr[w][req_idx]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    // Controller next-state, memory port and array-write decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wr_d        = wr_q;
        victim_d    = victim_q;
        vic_valid_d = vic_valid_q;
        k_d         = k_q;
        DataOut     = '0;
        Done        = 1'b0;
        CacheHit    = 1'b0;
        err         = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        arr_we      = 1'b0;
        line_fill   = 1'b0;
        dirty_set   = 1'b0;
        rr_adv      = 1'b0;
        arr_way     = victim_q;
        arr_idx     = cap_idx;
        arr_word    = k_q;
        arr_wdata   = mem_rdata;
        case (state_q)
            S_IDLE: begin
                if (Rd || Wr) begin
                    if (bad_req) begin
                        err = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        arr_way  = hit_way;
                        arr_idx  = req_idx;
                        arr_word = req_word;
                        if (Wr) begin
                            arr_we    = 1'b1;
                            arr_wdata = DataIn;
                            dirty_set = 1'b1;
                        end else begin
                            DataOut = data_arr[hit_way][req_idx][req_word];
                        end
                    end else begin
                        // Miss: freeze the request; invalid ways are preferred victims
                        addr_d      = Addr;
                        din_d       = DataIn;
                        wr_d        = Wr;
                        k_d         = '0;
                        victim_d    = any_inv ? inv_way : rr_q[req_idx];
                        vic_valid_d = !any_inv;
                        state_d     = (!any_inv && dirty_arr[rr_q[req_idx]][req_idx]) ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[victim_q][cap_idx], cap_idx, k_q, 1'b0};
                mem_wdata = data_arr[victim_q][cap_idx][k_q];
                if (mem_ack) begin
                    k_d = k_last ? '0 : k_q + OFF'(1);
                    if (k_last) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {cap_tag, cap_idx, k_q, 1'b0};
                if (mem_ack) begin
                    arr_we = 1'b1;
                    k_d    = k_last ? '0 : k_q + OFF'(1);
                    if (k_last) begin
                        line_fill = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                Done     = 1'b1;
                arr_word = cap_word;
                rr_adv   = vic_valid_q;
                if (wr_q) begin
                    arr_we    = 1'b1;
                    arr_wdata = din_q;
                    dirty_set = 1'b1;
                end else begin
                    DataOut = data_arr[victim_q][cap_idx][cap_word];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller state and captured request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            victim_q    <= '0;
            vic_valid_q <= 1'b0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            victim_q    <= victim_d;
            vic_valid_q <= vic_valid_d;
            k_q         <= k_d;
        end
    end

    // Valid/dirty bookkeeping; a reset leaves every line invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_arr[w][s] <= 1'b0;
                    dirty_arr[w][s] <= 1'b0;
                end
            end
        end else begin
            if (line_fill) begin
                valid_arr[arr_way][arr_idx] <= 1'b1;
                dirty_arr[arr_way][arr_idx] <= 1'b0;
            end
            if (dirty_set) begin
                dirty_arr[arr_way][arr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage (not reset; guarded by valid bits)
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_arr[arr_way][arr_idx][arr_word] <= arr_wdata;
        end
        if (line_fill) begin
            tag_arr[arr_way][arr_idx] <= cap_tag;
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            // Round-robin pointer moves only when a valid line was displaced
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        rr_q[s] <= '0;
                    end
                end else if (rr_adv) begin
                    rr_q[cap_idx] <= rr_q[cap_idx] + WAY_W'(1);
                end
            end
        end else begin : g_rr_tied
            // Direct-mapped: there is only one candidate way
            always_comb begin
                for (int s = 0; s < SETS; s++) begin
                    rr_q[s] = '0;
                end
            end
        end
    endgenerate

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, bumped on every completed access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (Done) begin
            if (CacheHit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
